// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
//   fetch_state_e : fetch sequencer states (FETCH, HALT)
//   PC_STEP       : byte increment between sequential instruction words
//   fetch_entry_t : prefetch buffer entry {pc, instr}
//   pc_is_legal   : word-aligned and inside the instruction memory
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // The limit is built 34 bits wide so MEM_WORDS*4 cannot overflow.
  function automatic logic pc_is_legal(input logic [31:0] pc,
                                       input int unsigned mem_words);
    logic [33:0] limit;
    limit = 34'(mem_words) << 2;
    return (pc[1:0] == 2'b00) && ({2'b00, pc} < limit);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instr} entries.
//   clk_i, rst_i : clock, asynchronous active-low reset (control only)
//   push, wdata  : write an entry (ignored while flushing)
//   pop          : advance the head (ignored when empty)
//   flush        : drop every entry; wins over push and pop
//   full, empty  : occupancy flags
//   head         : entry at the head (undefined when empty)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees the slot a full buffer needs.
  assign do_push = push && !flush && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; readers qualify it with empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a word-addressed, combinational-read instruction memory.
//   clk_i, rst_i           : clock, asynchronous active-low reset
//   imem_addr_o            : byte address to memory (the fetch PC)
//   imem_instr_i           : word returned for imem_addr_o in the same cycle
//   redirect_i/_pc_i       : flush the prefetch buffer and restart at a new PC
//   instr_o/instr_pc_o     : head instruction and its PC (0 when empty)
//   instr_valid_o/ready_i  : decode handshake
//   fetch_fault_o          : high while halted on an illegal fetch PC
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          MEM_WORDS  = 32,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic        fetch_fault_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;

  logic         pc_legal;
  logic         push;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign pc_legal = pc_is_legal(pc_q, MEM_WORDS);
  assign pop      = !fifo_empty && instr_ready_i;
  assign wr_entry = '{pc: pc_q, instr: imem_instr_i};

  // Redirect outranks everything; a HALT state never fetches.
  assign push = (state_q == FETCH) && pc_legal && !redirect_i
                && (!fifo_full || pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_i) begin
      // An illegal target is caught one edge later by the FETCH check.
      state_d = FETCH;
      pc_d    = redirect_pc_i;
    end else begin
      case (state_q)
        FETCH: begin
          if (!pc_legal) begin
            state_d = HALT;
          end else if (push) begin
            pc_d = pc_q + PC_STEP;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .flush (redirect_i),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Buffer storage is not reset, so the outputs are forced to 0 when empty.
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? 32'd0 : head.instr;
  assign instr_pc_o    = fifo_empty ? 32'd0 : head.pc;
  assign fetch_fault_o = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  localparam int MEMW  = 32;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .MEM_WORDS  (MEMW),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .imem_addr_o   (imem_addr),
    .imem_instr_i  (imem_instr),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .fetch_fault_o (fetch_fault)
  );

  // Instruction memory: word i holds 0x1000_0000 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_instr = (imem_addr < 32'(MEMW * 4)) ? mem_word(imem_addr)
                                                  : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending {pc, instr}, the fetch PC and a halt flag.
  logic [31:0] m_pc;
  bit          m_halt;
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", instr_pc, 32'd0);
      m_pc   = 32'd0;
      m_halt = 1'b0;
      q_pc.delete();
      q_ins.delete();
    end else begin
      bit pop;
      bit room;
      chk("valid", 32'(instr_valid), 32'(q_pc.size() != 0));
      chk("instr", instr, (q_ins.size() != 0) ? q_ins[0] : 32'd0);
      chk("instr_pc", instr_pc, (q_pc.size() != 0) ? q_pc[0] : 32'd0);
      chk("addr", imem_addr, m_pc);
      chk("fault", 32'(fetch_fault), 32'(m_halt));
      // Inputs only change just after a rising edge, so they are what the next edge sees.
      pop  = (q_pc.size() != 0) && instr_ready;
      room = (q_pc.size() < DEPTH) || pop;
      if (redirect) begin
        q_pc.delete();
        q_ins.delete();
        m_pc   = redirect_pc;
        m_halt = 1'b0;
      end else begin
        if (pop) begin
          void'(q_pc.pop_front());
          void'(q_ins.pop_front());
        end
        if (!m_halt) begin
          if ((m_pc % 4) != 0 || m_pc >= 32'(MEMW * 4)) begin
            m_halt = 1'b1;
          end else if (room) begin
            q_pc.push_back(m_pc);
            q_ins.push_back(mem_word(m_pc));
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    instr_ready = 1'b1;

    // 1. Reset release with the consumer always ready.
    repeat (2) after_edge();
    chk("t1_rst_addr", imem_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_valid_before_edge", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("t1_pc0", instr_pc, 32'h0);
    chk("t1_ins0", instr, 32'h1000_0000);
    @(negedge clk);
    chk("t1_pc4", instr_pc, 32'h4);
    chk("t1_ins4", instr, 32'h1000_0001);
    @(negedge clk);
    chk("t1_pc8", instr_pc, 32'h8);
    chk("t1_ins8", instr, 32'h1000_0002);

    // 2. Consumer stalls until the buffer is full, then resumes.
    after_edge();
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    after_edge();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t2_addr_hold", imem_addr, 32'h8);
    chk("t2_head_pc", instr_pc, 32'h0);
    chk("t2_head_ins", instr, 32'h1000_0000);
    after_edge();
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t2_pc4", instr_pc, 32'h4);

    // 3. Redirect to 0x40 while the buffer holds 8 and 12 and 8 is popped.
    after_edge();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    chk("t3_head8", instr_pc, 32'h8);
    after_edge();
    redirect = 1'b0;
    @(negedge clk);
    chk("t3_flushed", 32'(instr_valid), 32'd0);
    chk("t3_addr", imem_addr, 32'h40);
    @(negedge clk);
    chk("t3_pc40", instr_pc, 32'h40);
    chk("t3_ins40", instr, 32'h1000_0010);

    // 4. Run off the end of memory, then recover.
    after_edge();
    redirect    = 1'b1;
    redirect_pc = 32'h74;
    after_edge();
    redirect = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_pc7c", instr_pc, 32'h7C);
    chk("t4_nofault_yet", 32'(fetch_fault), 32'd0);
    @(negedge clk);
    chk("t4_fault", 32'(fetch_fault), 32'd1);
    chk("t4_drained", 32'(instr_valid), 32'd0);
    chk("t4_addr80", imem_addr, 32'h80);
    repeat (3) @(negedge clk);
    chk("t4_fault_sticky", 32'(fetch_fault), 32'd1);
    after_edge();
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    after_edge();
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_fault_clear", 32'(fetch_fault), 32'd0);
    @(negedge clk);
    chk("t4_resume_pc0", instr_pc, 32'h0);
    chk("t4_resume_valid", 32'(instr_valid), 32'd1);

    // 5. Misaligned redirect target.
    after_edge();
    redirect    = 1'b1;
    redirect_pc = 32'h42;
    after_edge();
    redirect = 1'b0;
    @(negedge clk);
    chk("t5_not_yet", 32'(fetch_fault), 32'd0);
    chk("t5_addr42", imem_addr, 32'h42);
    @(negedge clk);
    chk("t5_fault", 32'(fetch_fault), 32'd1);
    chk("t5_empty", 32'(instr_valid), 32'd0);

    // 6. Asynchronous reset with a full buffer.
    after_edge();
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    after_edge();
    redirect = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_full_addr", imem_addr, 32'h8);
    after_edge();
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(instr_valid), 32'd0);
    chk("t6_async_fault", 32'(fetch_fault), 32'd0);
    chk("t6_async_addr", imem_addr, 32'd0);
    after_edge();
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_restart_pc0", instr_pc, 32'h0);
    @(negedge clk);
    chk("t6_restart_pc4", instr_pc, 32'h4);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
